// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives operands and start. The slave returns status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (output start, a, b, bin, input  busy, done, diff, borrow_out);
  modport slave  (input  start, a, b, bin, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full_subtractor cell is reused each cycle, with its borrow registered between bits.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic difference,
  output logic borrow
);
  assign difference = a ^ b ^ c;
  assign borrow     = (~a & b) | (~(a ^ b) & c);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d, cell_b;

  full_subtractor u_cell (
    .a          (a_sh_q[0]),
    .b          (b_sh_q[0]),
    .c          (brw_q),
    .difference (cell_d),
    .borrow     (cell_b)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          brw_d    = bus.bin;
          cnt_d    = '0;
          res_sh_d = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        res_sh_d = {cell_d, res_sh_q[WIDTH-1:1]};
        brw_d    = cell_b;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The last bit step publishes the assembled result and the final borrow together.
        if (cnt_q == LAST) begin
          diff_d  = {cell_d, res_sh_q[WIDTH-1:1]};
          bout_d  = cell_b;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy       = (state_q == S_BUSY);
  assign bus.done       = (state_q == S_DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high across one edge; optionally leave start asserted.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit keep);
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    step();
    if (!keep) bus.start = 1'b0;
  endtask

  // Called one step after the accepting edge; checks latency, busy span, result, done width.
  task automatic wait_done(input string tag, input logic [W-1:0] ed, input logic eb);
    int n, nb;
    n  = 0;
    nb = bus.busy ? 1 : 0;
    while (!bus.done && n < 3 * W) begin
      step();
      n++;
      if (bus.busy) nb++;
    end
    chk({tag, " latency"}, n, W);
    chk({tag, " busy_cycles"}, nb, W);
    chk({tag, " diff"}, bus.diff, ed);
    chk({tag, " borrow_out"}, bus.borrow_out, eb);
    step();
    chk({tag, " done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C; bus.bin = 1'b0;
    step(); step();
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst diff", bus.diff, 8'h00);
    chk("rst borrow_out", bus.borrow_out, 1'b0);
    rst = 1'b0; bus.start = 1'b0;
    step();
    chk("rst stays idle", bus.busy, 1'b0);

    start_op(8'h5A, 8'h3C, 1'b0, 1'b0); wait_done("basic", 8'h1E, 1'b0);
    start_op(8'h00, 8'h01, 1'b0, 1'b0); wait_done("underflow0", 8'hFF, 1'b1);
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0); wait_done("underflowFF", 8'hFF, 1'b1);
    start_op(8'h80, 8'h7F, 1'b1, 1'b0); wait_done("ripple", 8'h00, 1'b0);
    start_op(8'h10, 8'h01, 1'b1, 1'b0); wait_done("misc", 8'h0E, 1'b0);

    // Start held high; operands change after capture and must not affect this result.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b1);
    bus.a = 8'h01; bus.b = 8'h02;
    wait_done("hold", 8'h1E, 1'b0);
    step();
    bus.start = 1'b0;
    chk("back2back accepted", bus.busy, 1'b1);
    chk("back2back diff held", bus.diff, 8'h1E);
    wait_done("back2back", 8'hFF, 1'b1);

    // Abort on the fourth bit-step edge.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", bus.busy, 1'b0);
    chk("abort diff", bus.diff, 8'h00);
    chk("abort borrow_out", bus.borrow_out, 1'b0);
    nd = 0;
    repeat (12) begin
      step();
      if (bus.done) nd++;
    end
    chk("abort no done", nd, 0);
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0); wait_done("after_abort", 8'h1E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
